// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit: FSM encodings, FUNCT3
// load/store encodings and the legality/alignment rule.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants exist only for loads; any other encoding is illegal.
  function automatic logic access_bad(input logic [2:0] f3,
                                      input logic [1:0] addr_lo,
                                      input logic       is_store);
    logic bad;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = addr_lo[0];
      F3_W:    bad = |addr_lo;
      F3_BU:   bad = is_store;
      F3_HU:   bad = is_store | addr_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational RV32I lane logic: store byte enables and replicated data,
// load lane extraction with sign/zero extension, and the fault flag.
module load_store_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  input  logic        i_is_store,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data,
  output logic        o_bad
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  assign o_bad     = access_bad(i_funct3, i_addr_lo, i_is_store);

  always_comb begin
    o_byte_en = 4'b0000;
    o_wdata   = 32'h0;
    if (i_is_store) begin
      case (i_funct3[1:0])
        2'b00: begin
          o_byte_en = 4'b0001 << i_addr_lo;
          o_wdata   = {4{i_store_data[7:0]}};
        end
        2'b01: begin
          o_byte_en = 4'b0011 << {i_addr_lo[1], 1'b0};
          o_wdata   = {2{i_store_data[15:0]}};
        end
        2'b10: begin
          o_byte_en = 4'b1111;
          o_wdata   = i_store_data;
        end
        default: begin
          o_byte_en = 4'b0000;
          o_wdata   = 32'h0;
        end
      endcase
    end
  end

  always_comb begin
    o_load_data = 32'h0;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_W:    o_load_data = i_rdata;
      F3_BU:   o_load_data = {24'h0, w_byte};
      F3_HU:   o_load_data = {16'h0, w_half};
      default: o_load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: accepts a load/store from EX/MEM, runs the
// request/busywait handshake with data memory and stalls until completion.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] ALU_RESULT,
  input  logic [31:0] STORE_DATA,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNCT3,
  output logic [31:0] LOAD_DATA,
  output logic        MEM_BUSY,
  output logic        MEM_DONE,
  output logic        MEM_FAULT,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WDATA,
  output logic [3:0]  DMEM_BYTE_EN,
  output logic        DMEM_READ,
  output logic        DMEM_WRITE,
  input  logic [31:0] DMEM_RDATA,
  input  logic        DMEM_BUSYWAIT,
  output logic [1:0]  DBG_STATE
);

  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]  r_addr_lo;
  logic [2:0]  r_funct3;
  logic        r_is_store;
  logic [31:0] r_load_data;
  logic        r_done;
  logic        r_fault;
  logic [31:0] r_dmem_addr;
  logic [31:0] r_dmem_wdata;
  logic [3:0]  r_dmem_be;
  logic        r_dmem_read;
  logic        r_dmem_write;

  logic        w_idle;
  logic        w_req;
  logic [1:0]  w_addr_lo;
  logic [2:0]  w_funct3;
  logic        w_is_store;
  logic [3:0]  w_byte_en;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;
  logic        w_bad;

  assign w_idle = (r_state == ST_IDLE);
  assign w_req  = MEM_READ | MEM_WRITE;

  // The aligner looks at the live request while idle, and at the latched
  // access afterwards so the load can be formatted in its completing cycle.
  assign w_addr_lo  = w_idle ? ALU_RESULT[1:0] : r_addr_lo;
  assign w_funct3   = w_idle ? FUNCT3          : r_funct3;
  assign w_is_store = w_idle ? MEM_WRITE       : r_is_store;

  load_store_align u_align (
    .i_addr_lo    (w_addr_lo),
    .i_funct3     (w_funct3),
    .i_is_store   (w_is_store),
    .i_store_data (STORE_DATA),
    .i_rdata      (DMEM_RDATA),
    .o_byte_en    (w_byte_en),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data),
    .o_bad        (w_bad)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_addr_lo    <= 2'b00;
      r_funct3     <= 3'b000;
      r_is_store   <= 1'b0;
      r_load_data  <= 32'h0;
      r_done       <= 1'b0;
      r_fault      <= 1'b0;
      r_dmem_addr  <= 32'h0;
      r_dmem_wdata <= 32'h0;
      r_dmem_be    <= 4'b0000;
      r_dmem_read  <= 1'b0;
      r_dmem_write <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done  <= 1'b0;
          r_fault <= 1'b0;
          if (w_req) begin
            if (w_bad) begin
              r_state     <= ST_RESP;
              r_done      <= 1'b1;
              r_fault     <= 1'b1;
              r_load_data <= 32'h0;
            end else begin
              r_state      <= ST_REQ;
              r_cnt        <= '0;
              r_addr_lo    <= ALU_RESULT[1:0];
              r_funct3     <= FUNCT3;
              r_is_store   <= MEM_WRITE;
              r_dmem_addr  <= {ALU_RESULT[31:2], 2'b00};
              r_dmem_wdata <= w_wdata;
              r_dmem_be    <= w_byte_en;
              r_dmem_read  <= ~MEM_WRITE;
              r_dmem_write <= MEM_WRITE;
            end
          end
        end
        ST_REQ: begin
          if (!DMEM_BUSYWAIT) begin
            r_state      <= ST_RESP;
            r_done       <= 1'b1;
            r_load_data  <= r_is_store ? 32'h0 : w_load_data;
            r_dmem_read  <= 1'b0;
            r_dmem_write <= 1'b0;
            r_dmem_be    <= 4'b0000;
          end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == CNT_MAX)) begin
            r_state      <= ST_RESP;
            r_done       <= 1'b1;
            r_fault      <= 1'b1;
            r_load_data  <= 32'h0;
            r_dmem_read  <= 1'b0;
            r_dmem_write <= 1'b0;
            r_dmem_be    <= 4'b0000;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_RESP: begin
          // Request inputs are still stale here; never re-accept them.
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_fault <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign MEM_BUSY     = (w_idle & w_req) | (r_state == ST_REQ);
  assign MEM_DONE     = r_done;
  assign MEM_FAULT    = r_fault;
  assign LOAD_DATA    = r_load_data;
  assign DMEM_ADDR    = r_dmem_addr;
  assign DMEM_WDATA   = r_dmem_wdata;
  assign DMEM_BYTE_EN = r_dmem_be;
  assign DMEM_READ    = r_dmem_read;
  assign DMEM_WRITE   = r_dmem_write;
  assign DBG_STATE    = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT_CYCLES = 4).
module tb_mem_access_unit;

  logic        CLK;
  logic        RESET;
  logic [31:0] ALU_RESULT;
  logic [31:0] STORE_DATA;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [2:0]  FUNCT3;
  logic [31:0] LOAD_DATA;
  logic        MEM_BUSY;
  logic        MEM_DONE;
  logic        MEM_FAULT;
  logic [31:0] DMEM_ADDR;
  logic [31:0] DMEM_WDATA;
  logic [3:0]  DMEM_BYTE_EN;
  logic        DMEM_READ;
  logic        DMEM_WRITE;
  logic [31:0] DMEM_RDATA;
  logic        DMEM_BUSYWAIT;
  logic [1:0]  DBG_STATE;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .ALU_RESULT    (ALU_RESULT),
    .STORE_DATA    (STORE_DATA),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .FUNCT3        (FUNCT3),
    .LOAD_DATA     (LOAD_DATA),
    .MEM_BUSY      (MEM_BUSY),
    .MEM_DONE      (MEM_DONE),
    .MEM_FAULT     (MEM_FAULT),
    .DMEM_ADDR     (DMEM_ADDR),
    .DMEM_WDATA    (DMEM_WDATA),
    .DMEM_BYTE_EN  (DMEM_BYTE_EN),
    .DMEM_READ     (DMEM_READ),
    .DMEM_WRITE    (DMEM_WRITE),
    .DMEM_RDATA    (DMEM_RDATA),
    .DMEM_BUSYWAIT (DMEM_BUSYWAIT),
    .DBG_STATE     (DBG_STATE)
  );

  // Clock / watchdog
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Drives one request, answers busywait for `waits` REQ cycles, and
  // collects what the memory side saw until MEM_DONE (bounded).
  task automatic run_access(input logic [31:0] addr, input logic [31:0] wd,
                            input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] rdata, input int waits,
                            output int n_busy, output int n_rd, output int n_wr,
                            output logic [31:0] s_addr, output logic [31:0] s_wd,
                            output logic [3:0] s_be, output logic [31:0] ld,
                            output logic flt, output logic seen, output logic sd);
    ALU_RESULT = addr; STORE_DATA = wd; MEM_READ = rd; MEM_WRITE = wr;
    FUNCT3 = f3; DMEM_RDATA = rdata; DMEM_BUSYWAIT = 1'b0;
    n_busy = 0; n_rd = 0; n_wr = 0; s_addr = 0; s_wd = 0; s_be = 0;
    ld = 0; flt = 0; seen = 0; sd = 0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (MEM_DONE) begin
        seen = 1'b1; ld = LOAD_DATA; flt = MEM_FAULT;
        sd = DMEM_READ | DMEM_WRITE | MEM_BUSY;
        break;
      end
      if (MEM_BUSY)   n_busy++;
      if (DMEM_READ)  n_rd++;
      if (DMEM_WRITE) n_wr++;
      if (DMEM_READ | DMEM_WRITE) begin
        s_addr = DMEM_ADDR; s_wd = DMEM_WDATA; s_be = DMEM_BYTE_EN;
      end
      DMEM_BUSYWAIT = ((n_rd + n_wr) > 0) && ((n_rd + n_wr) <= waits);
      @(posedge CLK);
    end
    MEM_READ = 1'b0; MEM_WRITE = 1'b0; DMEM_BUSYWAIT = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic access_and_check(input string tag, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic rd, input logic wr,
                                  input logic [2:0] f3, input logic [31:0] rdata,
                                  input int waits, input int e_busy, input int e_rd,
                                  input int e_wr, input logic [31:0] e_addr,
                                  input logic [31:0] e_wd, input logic [3:0] e_be,
                                  input logic [31:0] e_ld, input logic e_flt);
    int n_busy, n_rd, n_wr;
    logic [31:0] s_addr, s_wd, ld;
    logic [3:0] s_be;
    logic flt, seen, sd;
    exp_q.push_back(e_ld);
    run_access(addr, wd, rd, wr, f3, rdata, waits, n_busy, n_rd, n_wr,
               s_addr, s_wd, s_be, ld, flt, seen, sd);
    check({tag, ".done_seen"}, 32'(seen), 32'd1);
    check({tag, ".busy_cycles"}, n_busy, e_busy);
    check({tag, ".rd_cycles"}, n_rd, e_rd);
    check({tag, ".wr_cycles"}, n_wr, e_wr);
    check({tag, ".addr"}, s_addr, e_addr);
    check({tag, ".wdata"}, s_wd, e_wd);
    check({tag, ".byte_en"}, 32'(s_be), 32'(e_be));
    check({tag, ".load_data"}, ld, exp_q.pop_front());
    check({tag, ".fault"}, 32'(flt), 32'(e_flt));
    check({tag, ".strobe_busy_at_done"}, 32'(sd), 32'd0);
    check({tag, ".done_after"}, 32'(MEM_DONE), 32'd0);
    check({tag, ".state_after"}, 32'(DBG_STATE), 32'd0);
  endtask

  initial begin
    RESET = 1'b1; ALU_RESULT = 0; STORE_DATA = 0; MEM_READ = 0; MEM_WRITE = 0;
    FUNCT3 = 0; DMEM_RDATA = 0; DMEM_BUSYWAIT = 0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst.read",    32'(DMEM_READ), 32'd0);
    check("rst.write",   32'(DMEM_WRITE), 32'd0);
    check("rst.done",    32'(MEM_DONE), 32'd0);
    check("rst.fault",   32'(MEM_FAULT), 32'd0);
    check("rst.busy",    32'(MEM_BUSY), 32'd0);
    check("rst.ld",      LOAD_DATA, 32'h0);
    check("rst.addr",    DMEM_ADDR, 32'h0);
    check("rst.be",      32'(DMEM_BYTE_EN), 32'd0);
    check("rst.state",   32'(DBG_STATE), 32'd0);
    RESET = 1'b0;
    @(posedge CLK); #1;

    // tag, addr, wdata, rd, wr, f3, rdata, waits, busy, rd#, wr#, addr, wdata, be, ld, fault
    access_and_check("lw0",   32'h10, 0, 1, 0, 3'b010, 32'hDEADBEEF, 0, 2, 1, 0, 32'h10, 0, 4'b0000, 32'hDEADBEEF, 0);
    access_and_check("lb3",   32'h13, 0, 1, 0, 3'b000, 32'h80FF1234, 0, 2, 1, 0, 32'h10, 0, 4'b0000, 32'hFFFFFF80, 0);
    access_and_check("lbu3",  32'h13, 0, 1, 0, 3'b100, 32'h80FF1234, 0, 2, 1, 0, 32'h10, 0, 4'b0000, 32'h00000080, 0);
    access_and_check("lh2",   32'h12, 0, 1, 0, 3'b001, 32'h80FF1234, 0, 2, 1, 0, 32'h10, 0, 4'b0000, 32'hFFFF80FF, 0);
    access_and_check("lhu0",  32'h10, 0, 1, 0, 3'b101, 32'h80FF1234, 0, 2, 1, 0, 32'h10, 0, 4'b0000, 32'h00001234, 0);
    access_and_check("sh2",   32'h22, 32'h0000ABCD, 0, 1, 3'b001, 32'hFFFFFFFF, 0, 2, 0, 1, 32'h20, 32'hABCDABCD, 4'b1100, 0, 0);
    access_and_check("sb1",   32'h21, 32'h00000055, 0, 1, 3'b000, 32'hFFFFFFFF, 0, 2, 0, 1, 32'h20, 32'h55555555, 4'b0010, 0, 0);
    access_and_check("sw_rw", 32'h50, 32'h12345678, 1, 1, 3'b010, 32'hFFFFFFFF, 0, 2, 0, 1, 32'h50, 32'h12345678, 4'b1111, 0, 0);
    access_and_check("lw_w3", 32'h40, 0, 1, 0, 3'b010, 32'hCAFEF00D, 3, 5, 4, 0, 32'h40, 0, 4'b0000, 32'hCAFEF00D, 0);
    access_and_check("lw_mis", 32'h02, 0, 1, 0, 3'b010, 32'hFFFFFFFF, 0, 1, 0, 0, 0, 0, 4'b0000, 0, 1);
    access_and_check("lh_mis", 32'h01, 0, 1, 0, 3'b001, 32'hFFFFFFFF, 0, 1, 0, 0, 0, 0, 4'b0000, 0, 1);
    access_and_check("ld_ill", 32'h00, 0, 1, 0, 3'b011, 32'hFFFFFFFF, 0, 1, 0, 0, 0, 0, 4'b0000, 0, 1);
    access_and_check("st_ill", 32'h00, 32'h11, 0, 1, 3'b100, 32'hFFFFFFFF, 0, 1, 0, 0, 0, 0, 4'b0000, 0, 1);
    access_and_check("tmo",   32'h60, 0, 1, 0, 3'b010, 32'h11111111, 1000, 6, 5, 0, 32'h60, 0, 4'b0000, 0, 1);

    // Reset during the second busywait cycle of a load.
    ALU_RESULT = 32'h70; FUNCT3 = 3'b010; MEM_READ = 1'b1; DMEM_RDATA = 32'h99999999;
    DMEM_BUSYWAIT = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("rstmid.strobe_before", 32'(DMEM_READ), 32'd1);
    check("rstmid.state_before",  32'(DBG_STATE), 32'd1);
    RESET = 1'b1;
    @(posedge CLK); #1;
    check("rstmid.strobe_after", 32'(DMEM_READ), 32'd0);
    check("rstmid.state_after",  32'(DBG_STATE), 32'd0);
    check("rstmid.done",         32'(MEM_DONE), 32'd0);
    RESET = 1'b0; MEM_READ = 1'b0; DMEM_BUSYWAIT = 1'b0;
    @(posedge CLK); #1;
    check("rstmid.done_later",   32'(MEM_DONE), 32'd0);
    access_and_check("lw_post", 32'h74, 0, 1, 0, 3'b010, 32'h0BADF00D, 0, 2, 1, 0, 32'h74, 0, 4'b0000, 32'h0BADF00D, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
